// File: rtl/axi_bram_slave_if.sv
// -----------------------------------------------------------------------------
// axi_bram_slave_if
//   AXI4 bus between a cache-side master and the BRAM-backed memory
//   responder (axi_bram_slave). Carries the five AXI channels: AW, W, B, AR, R.
//   Clock and reset are not part of the bundle; they stay plain module ports.
//
//   Modports:
//     master : drives AW/W/AR payloads and valids, bready, rready
//     slave  : drives awready, wready, bvalid/bresp, arready, R payload/valid
// -----------------------------------------------------------------------------
interface axi_bram_slave_if;
    // Write address channel
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    // Write data channel
    logic        wvalid;
    logic        wready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    // Write response channel
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    // Read address channel
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    // Read data channel
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/axi_bram_slave.sv
// -----------------------------------------------------------------------------
// axi_bram_slave
//   AXI4 memory responder backed by a 64-bit wide on-chip BRAM. Serves INCR
//   bursts on independent, concurrently running read and write channels; one
//   write and one read burst may be outstanding at a time.
//
//   Parameters:
//     DEPTH_LOG2 : memory depth in 64-bit words (log2)
//     INIT_FILE  : initial memory image name; no image is loaded by this model
//
//   Ports:
//     clk : clock
//     rst : synchronous active-high reset (aborts bursts, keeps memory)
//     s   : AXI bus, slave modport of axi_bram_slave_if
//
//   Optional feature (macro AXI_SLAVE_RANDOM_STALL_EN):
//     a 16-bit LFSR injects random stalls on awready/arready/wready and holds
//     back new R beats, to exercise master backpressure handling.
// -----------------------------------------------------------------------------
module axi_bram_slave #(
    parameter int    DEPTH_LOG2 = 12,
    parameter string INIT_FILE  = ""
) (
    input  logic             clk,
    input  logic             rst,
    axi_bram_slave_if.slave  s
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int SUM_W = DEPTH_LOG2 + 9;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    typedef logic [DEPTH_LOG2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // Burst response decided once at address acceptance. The last-word sum is
    // wide enough that index+len can never wrap back into range.
    function automatic logic [1:0] burst_resp(input logic [31:3] word_addr,
                                              input logic [7:0]  len,
                                              input logic [2:0]  size,
                                              input logic [1:0]  burst);
        logic [SUM_W-1:0] last_idx;
        last_idx = SUM_W'(word_addr[DEPTH_LOG2+2:3]) + SUM_W'(len);
        if (size != 3'b011 || burst != 2'b01)
            return RESP_SLVERR;
        if (word_addr[31:DEPTH_LOG2+3] != '0 || last_idx > SUM_W'(DEPTH - 1))
            return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    // ---------------------------------------------------------------- stalls
    logic stall;
`ifdef AXI_SLAVE_RANDOM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 16'hACE1;
        else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign stall = lfsr[0];
`else
    assign stall = 1'b0;
`endif

    // ---------------------------------------------------------------- state
    w_state_e   w_state, w_state_nxt;
    r_state_e   r_state, r_state_nxt;

    idx_t       w_idx;
    logic [7:0] w_cnt;
    logic [1:0] w_err;      // address-phase verdict: gates memory writes
    logic [1:0] w_bresp;    // address verdict, overridden by wlast mismatch

    idx_t       a_idx;      // BRAM read address of the next beat to fetch
    logic       a_valid;
    logic [7:0] r_rem;      // beats still to fetch after the one at a_idx
    logic [1:0] r_err;

    logic        rvalid_q;
    logic [63:0] rdata_q;
    logic [1:0]  rresp_q;
    logic        rlast_q;

    logic [63:0] mem [DEPTH];

    // ------------------------------------------------------- next state/ready
    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = w_state;
        r_state_nxt = r_state;
        s.awready   = 1'b0;
        s.wready    = 1'b0;
        s.bvalid    = 1'b0;
        s.arready   = 1'b0;

        case (w_state)
            W_IDLE: begin
                s.awready = !stall;
                if (s.awvalid && !stall) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                s.wready = !stall;
                if (s.wvalid && !stall && w_cnt == 8'd0) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                s.bvalid = 1'b1;
                if (s.bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase

        case (r_state)
            R_IDLE: begin
                s.arready = !stall;
                if (s.arvalid && !stall) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                if (rvalid_q && s.rready && rlast_q) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    logic aw_hs, w_hs, ar_hs, out_adv, a_take;
    assign aw_hs = s.awvalid && s.awready;
    assign w_hs  = s.wvalid && s.wready;
    assign ar_hs = s.arvalid && s.arready;
    // The output register may load when empty or being drained this cycle;
    // otherwise the presented beat and the fetch address both hold.
    assign out_adv = !rvalid_q || s.rready;
    assign a_take  = out_adv && a_valid && !stall;

    // ---------------------------------------------------------------- write
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_err   <= RESP_OKAY;
            w_bresp <= RESP_OKAY;
        end else begin
            w_state <= w_state_nxt;
            if (aw_hs) begin
                w_idx   <= s.awaddr[DEPTH_LOG2+2:3];
                w_cnt   <= s.awlen;
                w_err   <= burst_resp(s.awaddr[31:3], s.awlen, s.awsize, s.awburst);
                w_bresp <= burst_resp(s.awaddr[31:3], s.awlen, s.awsize, s.awburst);
            end
            if (w_hs) begin
                w_idx <= w_idx + 1'b1;
                w_cnt <= w_cnt - 1'b1;
                if (s.wlast != (w_cnt == 8'd0)) w_bresp <= RESP_SLVERR;
            end
        end
    end

    // NOTE: the memory array is deliberately not reset; reset only aborts
    // bursts, and a reset branch here would prevent BRAM inference.
    always_ff @(posedge clk) begin
        if (!rst && w_hs && w_err == RESP_OKAY) begin
            for (int b = 0; b < 8; b++) begin
                if (s.wstrb[b]) mem[w_idx][8*b +: 8] <= s.wdata[8*b +: 8];
            end
        end
    end

    // ---------------------------------------------------------------- read
    // NOTE: the memory write above and this read are both non-blocking, so a
    // same-edge read of the word being written returns the old contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= R_IDLE;
            a_valid  <= 1'b0;
            a_idx    <= '0;
            r_rem    <= '0;
            r_err    <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            r_state <= r_state_nxt;
            if (ar_hs) begin
                a_valid <= 1'b1;
                a_idx   <= s.araddr[DEPTH_LOG2+2:3];
                r_rem   <= s.arlen;
                r_err   <= burst_resp(s.araddr[31:3], s.arlen, s.arsize, s.arburst);
            end else if (a_take) begin
                if (r_rem != 8'd0) begin
                    a_idx <= a_idx + 1'b1;
                    r_rem <= r_rem - 1'b1;
                end else begin
                    a_valid <= 1'b0;
                end
            end
            if (out_adv) begin
                rvalid_q <= a_take;
                if (a_take) begin
                    rdata_q <= (r_err == RESP_OKAY) ? mem[a_idx] : '0;
                    rresp_q <= r_err;
                    rlast_q <= (r_rem == 8'd0);
                end
            end
        end
    end

    assign s.bresp  = w_bresp;
    assign s.rvalid = rvalid_q;
    assign s.rdata  = rdata_q;
    assign s.rresp  = rresp_q;
    assign s.rlast  = rlast_q;
endmodule

// File: tb/tb_axi_bram_slave.sv
// -----------------------------------------------------------------------------
// tb_axi_bram_slave
//   Directed plus randomized bench for axi_bram_slave. A word-array reference
//   memory and an arithmetic response rule predict every burst outcome.
// -----------------------------------------------------------------------------
module tb_axi_bram_slave;
    localparam int DEPTH_LOG2 = 12;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_bram_slave_if s();

    axi_bram_slave #(.DEPTH_LOG2(DEPTH_LOG2), .INIT_FILE("")) dut (
        .clk (clk),
        .rst (rst),
        .s   (s)
    );

    always #5 clk = ~clk;

    int tests    = 0;
    int fails    = 0;
    int timeouts = 0;

    bit   [63:0] ref_mem [DEPTH];
    logic [63:0] wbuf [8];
    logic [7:0]  sbuf [8];
    logic [63:0] rd_q [$];
    logic [1:0]  rr_q [$];
    logic        rl_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Response rule: bad size/burst -> 2, last word past the end -> 3, else 0.
    function automatic logic [1:0] exp_resp(input logic [31:0] addr, input int len,
                                            input logic [2:0] size, input logic [1:0] burst);
        longint w;
        w = longint'(addr >> 3);
        if (size != 3'd3 || burst != 2'd1) return 2'd2;
        if (w + len > DEPTH - 1) return 2'd3;
        return 2'd0;
    endfunction

    task automatic model_write(input logic [31:0] addr, input int len, input logic [1:0] aresp);
        int idx;
        if (aresp != 2'd0) return;
        for (int b = 0; b <= len; b++) begin
            idx = int'(addr >> 3) + b;
            for (int k = 0; k < 8; k++)
                if (sbuf[b][k]) ref_mem[idx][8*k +: 8] = wbuf[b][8*k +: 8];
        end
    endtask

    function automatic logic [63:0] model_read(input logic [31:0] addr, input int beat,
                                               input logic [1:0] aresp);
        if (aresp != 2'd0) return 64'd0;
        return ref_mem[int'(addr >> 3) + beat];
    endfunction

    // Write burst from wbuf/sbuf; bad_last names the beat whose wlast is flipped.
    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input int bad_last,
                             output logic [1:0] resp, output logic b_on_time);
        int t;
        s.awaddr = addr; s.awlen = 8'(len); s.awsize = size; s.awburst = burst;
        s.awvalid = 1'b1;
        t = 0;
        while (!s.awready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeouts++;
        @(negedge clk);
        s.awvalid = 1'b0;
        for (int b = 0; b <= len; b++) begin
            s.wvalid = 1'b1;
            s.wdata  = wbuf[b];
            s.wstrb  = sbuf[b];
            s.wlast  = (b == len) ^ (b == bad_last);
            t = 0;
            while (!s.wready && t < 200) begin @(negedge clk); t++; end
            if (t >= 200) timeouts++;
            @(negedge clk);
        end
        s.wvalid = 1'b0;
        s.wlast  = 1'b0;
        b_on_time = s.bvalid;
        t = 0;
        while (!s.bvalid && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeouts++;
        resp = s.bresp;
        @(negedge clk);
    endtask

    // Read burst into rd_q/rr_q/rl_q. mode 0: rready=1, 1: 1,0,0 pattern,
    // 2: random. Cycle 0 is the AR handshake cycle. abort_beat>=0 pulses rst
    // while that beat is presented.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input int mode, input int abort_beat,
                            output int first_lat, output int last_cyc,
                            output int stable_err, output logic ar_back);
        int t, cyc, got;
        logic prev_v, prev_r, prev_l;
        logic [63:0] prev_d;
        logic [1:0]  prev_resp;
        rd_q.delete(); rr_q.delete(); rl_q.delete();
        first_lat = -1; last_cyc = -1; stable_err = 0; ar_back = 1'b0;
        s.araddr = addr; s.arlen = 8'(len); s.arsize = size; s.arburst = burst;
        s.arvalid = 1'b1;
        t = 0;
        while (!s.arready && t < 200) begin @(negedge clk); t++; end
        if (t >= 200) timeouts++;
        @(negedge clk);
        s.arvalid = 1'b0;
        cyc = 1; got = 0; prev_v = 1'b0; prev_r = 1'b0;
        prev_d = '0; prev_l = 1'b0; prev_resp = '0;
        while (got <= len && cyc < 300) begin
            case (mode)
                0:       s.rready = 1'b1;
                1:       s.rready = (cyc % 3 == 2);
                default: s.rready = 1'($urandom_range(0, 1));
            endcase
            if (prev_v && !prev_r &&
                (s.rvalid !== 1'b1 || s.rdata !== prev_d || s.rlast !== prev_l || s.rresp !== prev_resp))
                stable_err++;
            if (s.rvalid && first_lat < 0) first_lat = cyc;
            if (abort_beat >= 0 && got == abort_beat && s.rvalid) begin
                s.rready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("abort_rvalid", 64'(s.rvalid), 64'd0);
                check("abort_arready", 64'(s.arready), 64'd1);
                check("abort_awready", 64'(s.awready), 64'd1);
                return;
            end
            if (s.rvalid && s.rready) begin
                rd_q.push_back(s.rdata);
                rr_q.push_back(s.rresp);
                rl_q.push_back(s.rlast);
                got++;
                last_cyc = cyc;
            end
            prev_v = s.rvalid; prev_r = s.rready; prev_d = s.rdata;
            prev_l = s.rlast; prev_resp = s.rresp;
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) timeouts++;
        ar_back = s.arready && !s.rvalid;
        s.rready = 1'b0;
    endtask

    task automatic check_burst(input string tag, input logic [31:0] addr, input int len,
                               input logic [1:0] aresp);
        check($sformatf("%s_nbeats", tag), 64'(rd_q.size()), 64'(len + 1));
        for (int i = 0; i < rd_q.size() && i <= len; i++) begin
            check($sformatf("%s_data%0d", tag, i), rd_q[i], model_read(addr, i, aresp));
            check($sformatf("%s_resp%0d", tag, i), 64'(rr_q[i]), 64'(aresp));
            check($sformatf("%s_last%0d", tag, i), 64'(rl_q[i]), 64'(i == len));
        end
    endtask

    initial begin
        logic [1:0]  bresp, er;
        logic        on_time, ar_back;
        int          first_lat, last_cyc, stable_err;
        logic [63:0] old_word, new_word;
        int          idx, len, idx2, len2;
        logic [2:0]  size;

        s.awvalid = 0; s.awaddr = 0; s.awlen = 0; s.awsize = 0; s.awburst = 0;
        s.wvalid = 0; s.wdata = 0; s.wstrb = 0; s.wlast = 0; s.bready = 1;
        s.arvalid = 0; s.araddr = 0; s.arlen = 0; s.arsize = 0; s.arburst = 0;
        s.rready = 0;

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(s.awready), 64'd1);
        check("rst_arready", 64'(s.arready), 64'd1);
        check("rst_wready",  64'(s.wready),  64'd0);
        check("rst_bvalid",  64'(s.bvalid),  64'd0);
        check("rst_bresp",   64'(s.bresp),   64'd0);
        check("rst_rvalid",  64'(s.rvalid),  64'd0);
        check("rst_rdata",   s.rdata,        64'd0);
        check("rst_rresp",   64'(s.rresp),   64'd0);
        check("rst_rlast",   64'(s.rlast),   64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Zero-fill words 0..63 so every later read has a defined model value
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 8; b++) begin wbuf[b] = '0; sbuf[b] = 8'hFF; end
            axi_write(32'(k * 64), 7, 3'd3, 2'd1, -1, bresp, on_time);
            model_write(32'(k * 64), 7, 2'd0);
            check($sformatf("fill%0d_bresp", k), 64'(bresp), 64'd0);
        end

        // 8-beat burst at 0x40, then read it back with rready held high
        for (int b = 0; b < 8; b++) begin
            wbuf[b] = 64'(b) * 64'h1111_1111_1111_1111;
            sbuf[b] = 8'hFF;
        end
        axi_write(32'h40, 7, 3'd3, 2'd1, -1, bresp, on_time);
        model_write(32'h40, 7, 2'd0);
        check("burst_bresp", 64'(bresp), 64'd0);
        check("burst_b_one_cycle", 64'(on_time), 64'd1);
        axi_read(32'h40, 7, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check("burst_first_rvalid", 64'(first_lat), 64'd2);
        check("burst_done_cycle", 64'(last_cyc), 64'd9);
        check("burst_idle_after", 64'(ar_back), 64'd1);
        check_burst("burst", 32'h40, 7, 2'd0);

        // Partial strobe over a zero word
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; sbuf[0] = 8'h0F;
        axi_write(32'h40, 0, 3'd3, 2'd1, -1, bresp, on_time);
        model_write(32'h40, 0, 2'd0);
        axi_read(32'h40, 0, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check("strb_bresp", 64'(bresp), 64'd0);
        check("strb_nbeats", 64'(rd_q.size()), 64'd1);
        check("strb_data", rd_q[0], 64'h0000_0000_FFFF_FFFF);

        // Out-of-range read: DECERR with zero data on all beats
        er = exp_resp(32'h8000, 7, 3'd3, 2'd1);
        axi_read(32'h8000, 7, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check_burst("decerr", 32'h8000, 7, er);

        // Bad size on write: SLVERR and memory untouched
        wbuf[0] = 64'hDEAD_BEEF_CAFE_F00D; sbuf[0] = 8'hFF;
        er = exp_resp(32'h40, 0, 3'd2, 2'd1);
        axi_write(32'h40, 0, 3'd2, 2'd1, -1, bresp, on_time);
        model_write(32'h40, 0, er);
        check("slverr_bresp", 64'(bresp), 64'(er));
        axi_read(32'h40, 0, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check_burst("slverr_mem", 32'h40, 0, 2'd0);

        // Read with rready pattern 1,0,0,...: beats held while stalled
        axi_read(32'h40, 7, 3'd3, 2'd1, 1, -1, first_lat, last_cyc, stable_err, ar_back);
        check("stall_stable", 64'(stable_err), 64'd0);
        check_burst("stall", 32'h40, 7, 2'd0);

        // Early wlast: SLVERR, but the data is still written
        for (int b = 0; b < 4; b++) begin wbuf[b] = {$urandom, $urandom}; sbuf[b] = 8'hFF; end
        axi_write(32'h80, 3, 3'd3, 2'd1, 1, bresp, on_time);
        model_write(32'h80, 3, 2'd0);
        check("wlast_bresp", 64'(bresp), 64'd2);
        axi_read(32'h80, 3, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check_burst("wlast_mem", 32'h80, 3, 2'd0);

        // Same-cycle write and read of word 8: read-first
        old_word = ref_mem[8];
        new_word = {$urandom, $urandom};
        wbuf[0] = new_word; sbuf[0] = 8'hFF;
        fork
            axi_write(32'h40, 0, 3'd3, 2'd1, -1, bresp, on_time);
            axi_read(32'h40, 0, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        join
        check("collide_nbeats", 64'(rd_q.size()), 64'd1);
        check("collide_old", rd_q[0], old_word);
        model_write(32'h40, 0, 2'd0);
        axi_read(32'h40, 0, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check("collide_new", rd_q[0], new_word);

        // Reset on beat 3 of a read, then a clean re-read
        axi_read(32'h40, 7, 3'd3, 2'd1, 0, 3, first_lat, last_cyc, stable_err, ar_back);
        check("abort_beats_before", 64'(rd_q.size()), 64'd3);
        @(negedge clk);
        axi_read(32'h40, 7, 3'd3, 2'd1, 0, -1, first_lat, last_cyc, stable_err, ar_back);
        check_burst("after_abort", 32'h40, 7, 2'd0);

        // Randomized bursts within words 0..63 against the reference memory
        for (int it = 0; it < 24; it++) begin
            len  = $urandom_range(0, 7);
            idx  = $urandom_range(0, 63 - len);
            size = ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd3;
            for (int b = 0; b <= len; b++) begin
                wbuf[b] = {$urandom, $urandom};
                sbuf[b] = 8'($urandom_range(0, 255));
            end
            er = exp_resp(32'(idx * 8), len, size, 2'd1);
            axi_write(32'(idx * 8), len, size, 2'd1, -1, bresp, on_time);
            model_write(32'(idx * 8), len, er);
            check($sformatf("rnd%0d_bresp", it), 64'(bresp), 64'(er));
            len2 = $urandom_range(0, 7);
            idx2 = $urandom_range(0, 63 - len2);
            axi_read(32'(idx2 * 8), len2, 3'd3, 2'd1, 2, -1, first_lat, last_cyc, stable_err, ar_back);
            check($sformatf("rnd%0d_stable", it), 64'(stable_err), 64'd0);
            check_burst($sformatf("rnd%0d", it), 32'(idx2 * 8), len2, 2'd0);
        end

        check("timeouts", 64'(timeouts), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
